// File: rtl/adder_16_block.sv
// 3-bit + 3-bit + carry-in adder with a 4-bit registered sum, 1- or 2-cycle latency.
// Optional po_parity output is enabled by defining ADDER_16_PARITY_EN.
module adder_16_block #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic pi6,
  input  logic pi5,
  input  logic pi4,
  input  logic pi3,
  input  logic pi2,
  input  logic pi1,
  input  logic pi0,
  output logic po3,
  output logic po2,
  output logic po1,
  output logic po0,
  output logic out_valid
`ifdef ADDER_16_PARITY_EN
  ,
  output logic po_parity
`endif
);

  logic [2:0] w_a;
  logic [2:0] w_b;
  logic       w_cin;
  logic       w_v;
  logic [2:0] w_s;
  logic [3:0] w_c;
  logic [3:0] w_sum;

  logic [3:0] r_sum;
  logic       r_ov;

  generate
    if (LATENCY == 1) begin : g_lat1
      assign w_a   = {pi6, pi5, pi4};
      assign w_b   = {pi3, pi2, pi1};
      assign w_cin = pi0;
      assign w_v   = in_valid;
    end else if (LATENCY == 2) begin : g_lat2
      logic [2:0] r_a;
      logic [2:0] r_b;
      logic       r_cin;
      logic       r_v1;

      // Operands load only on accepted cycles, so idle inputs never reach the adder.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a   <= 3'b000;
          r_b   <= 3'b000;
          r_cin <= 1'b0;
          r_v1  <= 1'b0;
        end else begin
          r_v1 <= in_valid;
          if (in_valid) begin
            r_a   <= {pi6, pi5, pi4};
            r_b   <= {pi3, pi2, pi1};
            r_cin <= pi0;
          end
        end
      end

      assign w_a   = r_a;
      assign w_b   = r_b;
      assign w_cin = r_cin;
      assign w_v   = r_v1;
    end else begin : g_bad_latency
      $error("adder_16_block: LATENCY must be 1 or 2");
    end
  endgenerate

  // Ripple of three full adders; the last carry becomes sum bit 3.
  assign w_c[0] = w_cin;
  generate
    for (genvar i = 0; i < 3; i++) begin : g_fa
      assign w_s[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
      assign w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
    end
  endgenerate

  assign w_sum = {w_c[3], w_s};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= 4'b0000;
      r_ov  <= 1'b0;
    end else begin
      r_ov <= w_v;
      if (w_v) begin
        r_sum <= w_sum;
      end
    end
  end

`ifdef ADDER_16_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_v) begin
      r_parity <= ^w_sum;
    end
  end

  assign po_parity = r_parity;
`endif

  assign po3       = r_sum[3];
  assign po2       = r_sum[2];
  assign po1       = r_sum[1];
  assign po0       = r_sum[0];
  assign out_valid = r_ov;

endmodule

// File: tb/tb_adder_16_block.sv
// Directed bench for adder_16_block: one instance per legal LATENCY, driven in parallel.
// Parity checks are compiled in when ADDER_16_PARITY_EN is defined.
module tb_adder_16_block;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] pi;
  logic [3:0] po_a;
  logic [3:0] po_b;
  logic       ov_a;
  logic       ov_b;
`ifdef ADDER_16_PARITY_EN
  logic       par_a;
  logic       par_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adder_16_block #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .pi6(pi[6]), .pi5(pi[5]), .pi4(pi[4]), .pi3(pi[3]), .pi2(pi[2]), .pi1(pi[1]), .pi0(pi[0]),
    .po3(po_a[3]), .po2(po_a[2]), .po1(po_a[1]), .po0(po_a[0]),
    .out_valid(ov_a)
`ifdef ADDER_16_PARITY_EN
    , .po_parity(par_a)
`endif
  );

  adder_16_block #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .pi6(pi[6]), .pi5(pi[5]), .pi4(pi[4]), .pi3(pi[3]), .pi2(pi[2]), .pi1(pi[1]), .pi0(pi[0]),
    .po3(po_b[3]), .po2(po_b[2]), .po1(po_b[1]), .po0(po_b[0]),
    .out_valid(ov_b)
`ifdef ADDER_16_PARITY_EN
    , .po_parity(par_b)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_sum(input logic [6:0] v);
    int s;
    s = int'(v[6:4]) + int'(v[3:1]) + int'(v[0]);
    return 4'(s);
  endfunction

  task automatic idle_random();
    in_valid = 1'b0;
    pi       = 7'($urandom_range(0, 127));
  endtask

  // Hand-computed directed vectors: {pi6..pi0, sum}
  logic [6:0] dir_in  [5] = '{7'b0000000, 7'b0000001, 7'b1111111, 7'b1000010, 7'b0110101};
  logic [3:0] dir_exp [5] = '{4'b0000,    4'b0001,    4'b1111,    4'b0101,    4'b0110};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    pi       = 7'b1111111;
    tick();
    tick();
    chk("rst_po_l1", 8'(po_a), 8'h00);
    chk("rst_ov_l1", 8'(ov_a), 8'h00);
    chk("rst_po_l2", 8'(po_b), 8'h00);
    chk("rst_ov_l2", 8'(ov_b), 8'h00);
`ifdef ADDER_16_PARITY_EN
    chk("rst_par_l1", 8'(par_a), 8'h00);
    chk("rst_par_l2", 8'(par_b), 8'h00);
`endif

    // Exhaustive back-to-back sweep, starting on the first edge out of reset.
    rst_n = 1'b1;
    for (int v = 0; v < 128; v++) begin
      in_valid = 1'b1;
      pi       = 7'(v);
      tick();
      chk("exh_po_l1", 8'(po_a), 8'(ref_sum(7'(v))));
      chk("exh_ov_l1", 8'(ov_a), 8'h01);
      if (v == 0) begin
        chk("exh_first_ov_l2", 8'(ov_b), 8'h00);
      end else begin
        chk("exh_po_l2", 8'(po_b), 8'(ref_sum(7'(v - 1))));
        chk("exh_ov_l2", 8'(ov_b), 8'h01);
      end
`ifdef ADDER_16_PARITY_EN
      chk("exh_par_l1", 8'(par_a), 8'(^ref_sum(7'(v))));
`endif
    end
    idle_random();
    tick();
    chk("exh_tail_po_l2", 8'(po_b), 8'h0f);
    chk("exh_tail_ov_l2", 8'(ov_b), 8'h01);
    chk("exh_tail_ov_l1", 8'(ov_a), 8'h00);
    chk("exh_tail_po_l1", 8'(po_a), 8'h0f);
    idle_random();
    tick();

    // Single isolated inputs: latency and one-cycle out_valid pulse.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      pi       = dir_in[k];
      tick();
      chk("lat_e1_po_l1", 8'(po_a), 8'(dir_exp[k]));
      chk("lat_e1_ov_l1", 8'(ov_a), 8'h01);
      chk("lat_e1_ov_l2", 8'(ov_b), 8'h00);
      idle_random();
      tick();
      chk("lat_e2_ov_l1", 8'(ov_a), 8'h00);
      chk("lat_e2_po_l1", 8'(po_a), 8'(dir_exp[k]));
      chk("lat_e2_po_l2", 8'(po_b), 8'(dir_exp[k]));
      chk("lat_e2_ov_l2", 8'(ov_b), 8'h01);
      idle_random();
      tick();
      chk("lat_e3_ov_l1", 8'(ov_a), 8'h00);
      chk("lat_e3_ov_l2", 8'(ov_b), 8'h00);
    end

    // Hold: 1110001 -> 1000, then idle cycles with random operands.
    in_valid = 1'b1;
    pi       = 7'b1110001;
    tick();
    chk("hold_acc_po_l1", 8'(po_a), 8'h08);
    for (int i = 0; i < 5; i++) begin
      idle_random();
      tick();
      chk("hold_po_l1", 8'(po_a), 8'h08);
      chk("hold_ov_l1", 8'(ov_a), 8'h00);
      chk("hold_po_l2", 8'(po_b), 8'h08);
      chk("hold_ov_l2", 8'(ov_b), (i == 0) ? 8'h01 : 8'h00);
    end

    // Reset while 1111111 is in flight in the 2-cycle pipeline.
    in_valid = 1'b1;
    pi       = 7'b1111111;
    tick();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("midrst_po_l2", 8'(po_b), 8'h00);
    chk("midrst_ov_l2", 8'(ov_b), 8'h00);
    chk("midrst_po_l1", 8'(po_a), 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle_random();
      tick();
      chk("midrst_after_ov_l2", 8'(ov_b), 8'h00);
      chk("midrst_after_po_l2", 8'(po_b), 8'h00);
    end

`ifdef ADDER_16_PARITY_EN
    in_valid = 1'b1;
    pi       = 7'b0000111;
    tick();
    chk("par_0100_po_l1", 8'(po_a), 8'h04);
    chk("par_0100_l1", 8'(par_a), 8'h01);
    pi = 7'b1111111;
    tick();
    chk("par_1111_l1", 8'(par_a), 8'h00);
    chk("par_0100_l2", 8'(par_b), 8'h01);
    idle_random();
    tick();
    chk("par_1111_l2", 8'(par_b), 8'h00);
    chk("par_hold_l1", 8'(par_a), 8'h00);
    idle_random();
    tick();
    chk("par_hold_l2", 8'(par_b), 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
